msiq_feed: RTL and testbench

Snoop-intake stage directly upstream of the 8-entry self-modifying-code CAM (`msiq`). Accepts external line-invalidate addresses, deduplicates and buffers them in a small FIFO, and writes them into `msiq` through its `wrt_addr`/`wrt_en`/`wrt_can` port. It also tracks CAM occupancy, issues the `all_clear` pulse once the pipeline is quiet, and turns CAM hits into a held flush request.

---
 rtl/msiq_feed.sv | 177 +++++++++++++++++
 tb/tb_msiq_feed.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/msiq_feed.sv
// -----------------------------------------------------------------------------
// msiq_feed - snoop-intake stage feeding the 8-entry self-modifying-code CAM.
//
// Accepts line-invalidate addresses, drops duplicates of anything already
// buffered, queues the rest in a small FIFO and writes them into msiq through
// its wrt_addr/wrt_en/wrt_can port. Tracks how many CAM entries are in use,
// issues a one-cycle all_clear once the pipeline is quiet, and converts CAM
// hits into a flush request held until acknowledged.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   snp_addr/snp_en   incoming invalidate (37-bit line address) and valid
//   snp_rdy           intake ready (FIFO not full, registered count only)
//   wrt_addr/wrt_en   FIFO head and write strobe towards msiq
//   wrt_can           msiq has a free entry
//   all_clear         one-cycle pulse releasing every msiq entry
//   pipe_quiet        no older load/store in flight
//   smpc_hit          OR of msiq check hits
//   flush_req         flush request, held until flush_ack
//   flush_ack         flush taken
// -----------------------------------------------------------------------------

// One FIFO slot: holds an address plus valid bit and compares it against the
// incoming snoop for deduplication.
module msiq_feed_slot #(
  parameter int AW = 37
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          clr,
  input  logic [AW-1:0] din,
  input  logic [AW-1:0] cmp,
  output logic [AW-1:0] addr,
  output logic          hit
);
  logic vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      addr <= '0;
    end else if (set) begin
      vld  <= 1'b1;
      addr <= din;
    end else if (clr) begin
      vld  <= 1'b0;
    end
  end

  // Uses the registered valid, so a head being popped this cycle still matches.
  assign hit = vld & (addr == cmp);
endmodule

module msiq_feed #(
  parameter int DEPTH    = 4,
  parameter int CAM_WAYS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [36:0] snp_addr,
  input  logic        snp_en,
  output logic        snp_rdy,
  output logic [36:0] wrt_addr,
  output logic        wrt_en,
  input  logic        wrt_can,
  output logic        all_clear,
  input  logic        pipe_quiet,
  input  logic        smpc_hit,
  output logic        flush_req,
  input  logic        flush_ack
);
  localparam int AW = 37;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = $clog2(CAM_WAYS + 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);
  localparam logic [KW-1:0] CAM_FULL  = KW'(CAM_WAYS);

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL, CLEAR} state_t;

  state_t                       state, state_nxt;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                fifo_cnt;
  logic [KW-1:0]                cam_cnt;
  logic [DEPTH-1:0][AW-1:0]     slot_addr;
  logic [DEPTH-1:0]             slot_hit;
  logic                         dup, push, pop;

  // ---------------------------------------------------------------------------
  // Intake FIFO
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    msiq_feed_slot #(.AW(AW)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .set  (push & (wr_ptr == PW'(g))),
      .clr  (pop  & (rd_ptr == PW'(g))),
      .din  (snp_addr),
      .cmp  (snp_addr),
      .addr (slot_addr[g]),
      .hit  (slot_hit[g])
    );
  end

  // Ready depends only on the registered count: a pop this cycle does not
  // open a slot for a push in the same cycle.
  assign snp_rdy  = (fifo_cnt != FIFO_FULL);
  assign dup      = |slot_hit;
  assign push     = snp_en & snp_rdy & ~dup;

  assign wrt_addr = slot_addr[rd_ptr];
  assign wrt_en   = (fifo_cnt != '0) & wrt_can & (cam_cnt != CAM_FULL) &
                    ((state == IDLE) | (state == ACTIVE));
  assign pop      = wrt_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // CAM occupancy and clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cam_cnt <= '0;
    else if (state == CLEAR) cam_cnt <= '0;
    else if (wrt_en)         cam_cnt <= cam_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wrt_en) state_nxt = ACTIVE;
      ACTIVE: begin
        if ((cam_cnt == CAM_FULL) || (!wrt_can && (fifo_cnt != '0)))
          state_nxt = FULL;
        else if (pipe_quiet && (fifo_cnt == '0) && !wrt_en)
          state_nxt = CLEAR;
      end
      FULL:    if (pipe_quiet) state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // all_clear is a flop loaded with "entering CLEAR", so it is high exactly
  // for the CLEAR cycle, where wrt_en is already forced low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      all_clear <= 1'b0;
    end else begin
      state     <= state_nxt;
      all_clear <= (state_nxt == CLEAR);
    end
  end

  // ---------------------------------------------------------------------------
  // Flush request: a new hit beats a simultaneous ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_req <= 1'b0;
    else      flush_req <= smpc_hit | (flush_req & ~flush_ack);
  end
endmodule

// File: tb/tb_msiq_feed.sv
module tb_msiq_feed;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [36:0] snp_addr = '0;
  logic        snp_en = 1'b0;
  logic        snp_rdy;
  logic [36:0] wrt_addr;
  logic        wrt_en;
  logic        wrt_can = 1'b1;
  logic        all_clear;
  logic        pipe_quiet = 1'b0;
  logic        smpc_hit = 1'b0;
  logic        flush_req;
  logic        flush_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [1:0] S_I = 2'd0, S_A = 2'd1, S_F = 2'd2, S_C = 2'd3;
  localparam logic [36:0] A = 37'h0_1234_5678, B = 37'h1_0000_0001,
                          C = 37'h0_ABCD_EF01, D = 37'h1_FFFF_FFFF,
                          E = 37'h0_0000_0040, X1 = 37'h0_7000_0000,
                          X2 = 37'h0_7000_0100, X3 = 37'h0_7000_0200,
                          Y = 37'h1_2222_3333, W0 = 37'h0_3000_0000,
                          V = 37'h1_5555_AAAA;

  msiq_feed #(.DEPTH(4), .CAM_WAYS(8)) dut (
    .clk(clk), .rst(rst), .snp_addr(snp_addr), .snp_en(snp_en),
    .snp_rdy(snp_rdy), .wrt_addr(wrt_addr), .wrt_en(wrt_en),
    .wrt_can(wrt_can), .all_clear(all_clear), .pipe_quiet(pipe_quiet),
    .smpc_hit(smpc_hit), .flush_req(flush_req), .flush_ack(flush_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [36:0] addr;
    logic        can, quiet, hit, ack;
    logic        rdy, wen;
    logic [36:0] waddr;
    logic        aclr, freq;
    logic [1:0]  st;
    logic [2:0]  fcnt;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(logic en, logic [36:0] addr, logic can, logic quiet,
                              logic hit, logic ack, logic rdy, logic wen,
                              logic [36:0] waddr, logic aclr, logic freq,
                              logic [1:0] st, logic [2:0] fcnt);
    vec_t v;
    v.en = en; v.addr = addr; v.can = can; v.quiet = quiet; v.hit = hit;
    v.ack = ack; v.rdy = rdy; v.wen = wen; v.waddr = waddr; v.aclr = aclr;
    v.freq = freq; v.st = st; v.fcnt = fcnt;
    return v;
  endfunction

  function automatic logic [36:0] zaddr(int i);
    return 37'h0_5000_0000 + 37'(i) * 37'h40;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushed, writes;
    // en addr can q hit ack | rdy wen waddr aclr freq st fcnt
    vecs[0]  = mk(1, A, 1,0,0,0, 1,0,'0,0,0,S_I,0);
    vecs[1]  = mk(0,'0, 1,0,0,0, 1,1, A,0,0,S_I,1);
    vecs[2]  = mk(0,'0, 1,1,0,0, 1,0,'0,0,0,S_A,0);
    vecs[3]  = mk(0,'0, 1,0,0,0, 1,0,'0,1,0,S_C,0);
    vecs[4]  = mk(1, A, 0,0,0,0, 1,0,'0,0,0,S_I,0);
    vecs[5]  = mk(1, B, 0,0,0,0, 1,0,'0,0,0,S_I,1);
    vecs[6]  = mk(1, A, 0,0,0,0, 1,0,'0,0,0,S_I,2);
    vecs[7]  = mk(1, C, 0,0,0,0, 1,0,'0,0,0,S_I,2);
    vecs[8]  = mk(1, D, 0,0,0,0, 1,0,'0,0,0,S_I,3);
    vecs[9]  = mk(1, E, 0,0,0,0, 0,0,'0,0,0,S_I,4);
    vecs[10] = mk(0,'0, 1,0,0,0, 0,1, A,0,0,S_I,4);
    vecs[11] = mk(0,'0, 1,0,0,0, 1,1, B,0,0,S_A,3);
    vecs[12] = mk(0,'0, 1,0,0,0, 1,1, C,0,0,S_A,2);
    vecs[13] = mk(0,'0, 1,0,0,0, 1,1, D,0,0,S_A,1);
    vecs[14] = mk(0,'0, 1,0,1,0, 1,0,'0,0,0,S_A,0);
    vecs[15] = mk(0,'0, 1,0,0,0, 1,0,'0,0,1,S_A,0);
    vecs[16] = mk(0,'0, 1,0,0,0, 1,0,'0,0,1,S_A,0);
    vecs[17] = mk(0,'0, 1,0,1,0, 1,0,'0,0,1,S_A,0);
    vecs[18] = mk(0,'0, 1,0,0,0, 1,0,'0,0,1,S_A,0);
    vecs[19] = mk(0,'0, 1,0,0,1, 1,0,'0,0,1,S_A,0);
    vecs[20] = mk(0,'0, 1,0,0,0, 1,0,'0,0,0,S_A,0);
    vecs[21] = mk(0,'0, 1,0,1,0, 1,0,'0,0,0,S_A,0);
    vecs[22] = mk(0,'0, 1,0,0,0, 1,0,'0,0,1,S_A,0);
    vecs[23] = mk(0,'0, 1,0,1,1, 1,0,'0,0,1,S_A,0);
    vecs[24] = mk(0,'0, 1,0,0,0, 1,0,'0,0,1,S_A,0);
    vecs[25] = mk(0,'0, 1,0,0,1, 1,0,'0,0,1,S_A,0);
    vecs[26] = mk(0,'0, 1,0,0,0, 1,0,'0,0,0,S_A,0);

    // Reset values while held in reset
    #3;
    chk("rst_rdy", snp_rdy, 1);
    chk("rst_wen", wrt_en, 0);
    chk("rst_aclr", all_clear, 0);
    chk("rst_freq", flush_req, 0);
    chk("rst_state", dut.state, S_I);
    #9 rst = 1'b1;

    // Table: basic drain, dedup/full FIFO, flush handshake
    for (int i = 0; i < 27; i++) begin
      cyc();
      snp_en = vecs[i].en; snp_addr = vecs[i].addr; wrt_can = vecs[i].can;
      pipe_quiet = vecs[i].quiet; smpc_hit = vecs[i].hit; flush_ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_rdy", i), snp_rdy, vecs[i].rdy);
      chk($sformatf("v%0d_wen", i), wrt_en, vecs[i].wen);
      if (vecs[i].wen) chk($sformatf("v%0d_waddr", i), wrt_addr, vecs[i].waddr);
      chk($sformatf("v%0d_aclr", i), all_clear, vecs[i].aclr);
      chk($sformatf("v%0d_freq", i), flush_req, vecs[i].freq);
      chk($sformatf("v%0d_state", i), dut.state, vecs[i].st);
      chk($sformatf("v%0d_fcnt", i), dut.fifo_cnt, vecs[i].fcnt);
    end
    smpc_hit = 0; flush_ack = 0; snp_en = 0;

    // Quiet clear, then three writes, clear again with a push in CLEAR
    cyc(); pipe_quiet = 1; #1; chk("q0_state", dut.state, S_A);
    cyc(); pipe_quiet = 0; #1; chk("q1_state", dut.state, S_C); chk("q1_aclr", all_clear, 1);
    cyc(); snp_en = 1; snp_addr = X1; #1;
    chk("q2_state", dut.state, S_I); chk("q2_cam", dut.cam_cnt, 0); chk("q2_aclr", all_clear, 0);
    cyc(); snp_addr = X2; #1; chk("q3_wen", wrt_en, 1); chk("q3_waddr", wrt_addr, X1);
    cyc(); snp_addr = X3; #1; chk("q4_wen", wrt_en, 1); chk("q4_waddr", wrt_addr, X2);
    cyc(); snp_en = 0; #1; chk("q5_wen", wrt_en, 1); chk("q5_waddr", wrt_addr, X3);
    cyc(); pipe_quiet = 1; #1;
    chk("q6_cam", dut.cam_cnt, 3); chk("q6_fcnt", dut.fifo_cnt, 0); chk("q6_state", dut.state, S_A);
    cyc(); pipe_quiet = 0; snp_en = 1; snp_addr = Y; #1;
    chk("q7_state", dut.state, S_C); chk("q7_aclr", all_clear, 1);
    chk("q7_wen", wrt_en, 0); chk("q7_rdy", snp_rdy, 1);
    cyc(); snp_en = 0; #1;
    chk("q8_state", dut.state, S_I); chk("q8_cam", dut.cam_cnt, 0); chk("q8_aclr", all_clear, 0);
    chk("q8_wen", wrt_en, 1); chk("q8_waddr", wrt_addr, Y);
    cyc(); pipe_quiet = 1; #1; chk("q9_aclr", all_clear, 0); chk("q9_wen", wrt_en, 0);
    cyc(); pipe_quiet = 0; #1; chk("q10_state", dut.state, S_C);
    cyc(); #1; chk("q11_state", dut.state, S_I); chk("q11_cam", dut.cam_cnt, 0);

    // CAM full: ten distinct addresses, pipe not quiet
    pushed = 0; writes = 0;
    for (int k = 0; k < 14; k++) begin
      cyc();
      snp_en = (pushed < 10); snp_addr = zaddr(pushed);
      #1;
      if (all_clear && wrt_en) chk("cam_aclr_wen_overlap", 1, 0);
      if (wrt_en) begin
        chk($sformatf("cam_waddr%0d", writes), wrt_addr, zaddr(writes));
        writes++;
      end
      if (snp_en && snp_rdy) pushed++;
    end
    snp_en = 0;
    chk("cam_writes", writes, 8);
    chk("cam_pushed", pushed, 10);
    chk("cam_state", dut.state, S_F);
    chk("cam_fcnt", dut.fifo_cnt, 2);
    chk("cam_cnt", dut.cam_cnt, 8);
    cyc(); pipe_quiet = 1; #1; chk("r0_wen", wrt_en, 0); chk("r0_state", dut.state, S_F);
    cyc(); pipe_quiet = 0; #1;
    chk("r1_state", dut.state, S_C); chk("r1_aclr", all_clear, 1); chk("r1_wen", wrt_en, 0);
    cyc(); #1;
    chk("r2_state", dut.state, S_I); chk("r2_aclr", all_clear, 0);
    chk("r2_wen", wrt_en, 1); chk("r2_waddr", wrt_addr, zaddr(8));
    cyc(); #1; chk("r3_wen", wrt_en, 1); chk("r3_waddr", wrt_addr, zaddr(9));
    cyc(); #1; chk("r4_wen", wrt_en, 0); chk("r4_aclr", all_clear, 0);

    // Async reset with FIFO=3 in FULL and a pending flush
    cyc(); wrt_can = 0; snp_en = 1; snp_addr = W0; #1;
    cyc(); snp_addr = W0 + 37'h40; smpc_hit = 1; #1;
    chk("s1_state", dut.state, S_A); chk("s1_fcnt", dut.fifo_cnt, 1);
    cyc(); snp_addr = W0 + 37'h80; smpc_hit = 0; #1;
    chk("s2_state", dut.state, S_F); chk("s2_freq", flush_req, 1);
    cyc(); snp_en = 0; wrt_can = 1; #1;
    chk("s3_state", dut.state, S_F); chk("s3_fcnt", dut.fifo_cnt, 3); chk("s3_rdy", snp_rdy, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_rdy", snp_rdy, 1); chk("ar_wen", wrt_en, 0); chk("ar_aclr", all_clear, 0);
    chk("ar_freq", flush_req, 0); chk("ar_state", dut.state, S_I);
    chk("ar_fcnt", dut.fifo_cnt, 0); chk("ar_cam", dut.cam_cnt, 0);
    #1 rst = 1'b1;
    cyc(); snp_en = 1; snp_addr = V; #1; chk("v0_wen", wrt_en, 0);
    cyc(); snp_en = 0; #1;
    chk("v1_wen", wrt_en, 1); chk("v1_waddr", wrt_addr, V);
    chk("v1_fcnt", dut.fifo_cnt, 1); chk("v1_aclr", all_clear, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
